// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage. Owns the PC, drives the word-aligned
//            fetch address to a combinational instruction memory, and loads
//            the returned word plus its PC into the IF/ID register. Handles
//            decode stalls, branch/jump redirects (flush) and EBREAK halting.
// Options  : FETCH_PERF_CNT_EN - when defined, fetch_count/stall_count are
//            live 32-bit counters; otherwise both ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_id_pc_nxt;
  logic [31:0] if_id_instr_nxt;
  logic        if_id_valid_nxt;

  // The memory is addressed straight from the PC register.
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next PC / IF/ID values; redirect beats stall beats accept.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_id_pc_nxt    = if_id_pc;
    if_id_instr_nxt = if_id_instr;
    if_id_valid_nxt = if_id_valid;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN, HALT: begin
        if (redirect_valid) begin
          // Low address bits of the target are dropped to stay word-aligned.
          pc_nxt          = {redirect_pc[31:2], 2'b00};
          if_id_valid_nxt = 1'b0;
          if_id_instr_nxt = NOP_INSTR;
          state_nxt       = RUN;
        end else if (stall) begin
          // Everything holds.
        end else if (state == HALT) begin
          // Halted: feed bubbles into decode, PC frozen on the EBREAK.
          if_id_valid_nxt = 1'b0;
          if_id_instr_nxt = NOP_INSTR;
        end else begin
          if_id_instr_nxt = imem_rdata;
          if_id_pc_nxt    = pc;
          if_id_valid_nxt = 1'b1;
          if (imem_rdata == EBREAK_INSTR) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = pc + 32'd4;
          end
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_valid <= if_id_valid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        accept;
  logic        stall_cyc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  assign accept    = (state == RUN) && !redirect_valid && !stall;
  assign stall_cyc = (state != BOOT) && stall && !redirect_valid;

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (accept)    fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_cyc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt;
  assign stall_count = stall_cnt;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule
`default_nettype wire
